// File: rtl/alu_pkg.sv
// Shared types for the ALU flag stage: NZCV flag layout and skid-buffer states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

    // Bit positions of each flag within the 4-bit NZCV word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Field order matches the FLAG_* positions above (n is the MSB).
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: an output register plus one skid register.
// Latency: 1 cycle from accept to out_valid when empty.
// Backpressure: in_ready is a flop that drops only when both entries hold data; out_ready has no combinational path to it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload (held stable while stalled)
module skid_buffer
    import alu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    skid_state_t   state;
    skid_state_t   state_nxt;
    logic [DW-1:0] skid_data;
    logic          accept;
    logic          xfer;
    logic          load_out_in;
    logic          load_out_skid;
    logic          load_skid;

    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign out_valid = (state != EMPTY);

    always_comb begin
        state_nxt     = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt   = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !xfer) begin
                    // Output register is stalled: park the new word in the skid entry.
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (!accept && xfer) begin
                    state_nxt = EMPTY;
                end else if (accept && xfer) begin
                    load_out_in = 1'b1;
                end
            end
            FULL: begin
                // in_ready is low here, so accept cannot occur.
                if (xfer) begin
                    state_nxt     = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            state    <= state_nxt;
            // Registered copy of "not full next cycle" keeps in_ready a pure flop output.
            in_ready <= (state_nxt != FULL);
            if (load_out_in) begin
                out_data <= in_data;
            end else if (load_out_skid) begin
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_flag_stage.sv
// ALU output stage: forms NZCV flags, buffers {result, flags} downstream, keeps the status register.
// Latency: 1 cycle from accept to out_valid; status updates the cycle after accept regardless of stall.
// Backpressure: two-entry skid buffer; in_ready drops only after two words are stalled.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          ALU handshake; in_result, in_carry, in_overflow, in_zero_n (active-low zero)
//   in_flag_we                 accepted word updates status
//   status_clr                 synchronous clear of status (and flag_err), wins over update
//   out_valid/out_ready        downstream handshake; out_result, out_flags {N,Z,C,V}
//   status                     architectural NZCV register
//   flag_err                   sticky zero-flag mismatch; live only when FLAG_CHECK_EN is defined, else 0
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic             in_zero_n,
    input  logic             in_flag_we,
    input  logic             status_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       status,
    output logic             flag_err
);

    flags_t             flags;
    logic               accept;
    logic [WIDTH+3:0]   out_data;

    always_comb begin
        flags   = '0;
        flags.n = in_result[WIDTH-1];
        flags.z = ~in_zero_n;
        flags.c = in_carry;
        flags.v = in_overflow;
    end

    assign accept = in_valid && in_ready;

    skid_buffer #(
        .DW (WIDTH + 4)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_result, flags}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign out_result = out_data[WIDTH+3:4];
    assign out_flags  = out_data[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else if (status_clr) begin
            status <= '0;
        end else if (accept && in_flag_we) begin
            status <= flags;
        end
    end

`ifdef FLAG_CHECK_EN
    // The zero flag itself still follows in_zero_n; this only reports disagreement.
    logic zero_mismatch;
    assign zero_mismatch = (in_zero_n != (in_result != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_err <= 1'b0;
        end else if (status_clr) begin
            flag_err <= 1'b0;
        end else if (accept && zero_mismatch) begin
            flag_err <= 1'b1;
        end
    end
`else
    assign flag_err = 1'b0;
`endif

endmodule
